serial_addsub: RTL
==================

# serial_addsub

Bit-serial add/subtract unit for the 8-bit ALU datapath, placed directly downstream of the two's complementor stage. It accepts two SIZE-bit operands with a start strobe and processes one bit per clock, LSB first. Subtraction uses two's-complement negation of `b` (invert plus carry-in of 1), so the result matches `a + twos_comp(b)`. It produces a SIZE-bit result and carry, overflow, zero and negative flags, with a one-cycle done pulse.

## Interface
- `SIZE`, default 8: operand and result width in bits (minimum 2).

- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: begin an operation. Sampled only in IDLE.
- `sub` input, 1 bit: 0 selects `a + b`, 1 selects `a - b`. Sampled together with `start`.
- `a` input, SIZE bits: operand A, sampled with `start`.
- `b` input, SIZE bits: operand B, sampled with `start`.
- `busy` output, 1 bit: high while an operation is in progress.
- `done` output, 1 bit: single-cycle pulse when the result and flags update.
- `result` output, SIZE bits: registered result of the last completed operation.
- `carry` output, 1 bit: carry out of the MSB. For subtraction this means not-borrow: 1 when `a >= b` unsigned.
- `overflow` output, 1 bit: signed overflow, equal to carry into the MSB XOR carry out of the MSB.
- `zero` output, 1 bit: 1 when the completed `result` is 0.
- `negative` output, 1 bit: equal to `result[SIZE-1]`.

## Operation
- **States:** IDLE and BUSY. A bit counter of width clog2(SIZE)+1 tracks progress.
- **IDLE, start=1:**
  - Load shift register A with `a`.
  - Load shift register B with `b` when `sub`=0, or `~b` when `sub`=1.
  - Set the carry flip-flop to `sub` and clear the counter.
  - Move to BUSY.
- **BUSY, every cycle:**
  - Sum bit = A[0] ^ B[0] ^ c.
  - Next carry = majority(A[0], B[0], c).
  - Shift the sum bit into the internal result shift register from the MSB side.
  - Shift A and B right by one and increment the counter.
  - On the cycle that processes bit SIZE-1:
    - Capture the carry into the MSB for the overflow calculation.
    - Load `result` from the completed shift register.
    - Load `carry`, `overflow`, `zero` and `negative`.
    - Assert `done` and return to IDLE.
- **Output hold:** `result` and the flags change only on completion. They hold their value until the next completion or until reset.
- **start while BUSY:** ignored. The in-flight operation is not disturbed and no request is queued.
- **Operand changes while BUSY:** `a`, `b` and `sub` are don't-care; only the values sampled at start are used.
- **Reset:**
  - Values after reset: state IDLE; `busy`, `done`, `result`, `carry`, `overflow`, `zero` and `negative` all 0 (`zero` is 0 even though `result` is 0); internal shift registers and counter cleared.
  - Reset asserted mid-operation aborts it: no `done` pulse, and the partial result is discarded.
  - `rst` and `start` in the same cycle: reset wins.
- **Arithmetic:** modulo 2^SIZE. The result equals the low SIZE bits of `a + b` or `a + ~b + 1`.

## Timing
- **Edge numbering:** the edge that samples `start` in IDLE is edge 0.
- **busy:** reads 1 after edge 0 and through edge SIZE-1. It reads 0 after edge SIZE.
- **Bit processing:** bit i (0..SIZE-1) is processed at edge i+1.
- **done:** reads 1 for exactly one cycle after edge SIZE. `result` and the flags are valid in that same cycle.
- **Latency:** SIZE cycles from start sampling to done.
- **Back-to-back issue:** `start` may be asserted while `done`=1, because the state is already IDLE. That start is accepted, giving a throughput of one operation every SIZE+1 cycles.
- **Asserting start:** `start` may be held high continuously. A new operation is accepted in each cycle spent in IDLE.

## Test plan
- **ADD 0x05 + 0x03:**
  - Required response: `result`=0x08, `carry`=0, `overflow`=0, `zero`=0, `negative`=0.
  - `done` pulses exactly 8 cycles after the start edge, and `busy` is high for 8 cycles.
- **SUB 0x00 − 0x04:** `result`=0xFC (the two's complement of 4), `carry`=0, `negative`=1, `overflow`=0, `zero`=0.
- **Signed overflow:**
  - SUB 0x7F − 0x80 gives `result`=0xFF, `overflow`=1, `carry`=0, `negative`=1.
  - ADD 0x80 + 0x80 gives `result`=0x00, `carry`=1, `overflow`=1, `zero`=1.
- **SUB 0x05 − 0x05:** `result`=0x00, `zero`=1, `carry`=1, `overflow`=0. Then immediately issue ADD 0xFF + 0x01 in the `done` cycle: `result`=0x00, `carry`=1, and its `done` arrives 8 cycles later.
- **start during BUSY:** pulse `start` with different operands 3 cycles into an ADD 0x10 + 0x20.
  - Required response: `result`=0x30 and only one `done` pulse.
- **Reset mid-operation:** assert `rst` 4 cycles into SUB 0x09 − 0x02.
  - Required response: all outputs 0 on the next cycle and no `done` pulse.
  - A subsequent ADD 0x01 + 0x01 gives `result`=0x02.

Source files
------------

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract unit: one bit per clock, LSB first, with registered
// result and carry/overflow/zero/negative flags plus a one-cycle done pulse.
module serial_addsub #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            sub,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] result,
  output logic            carry,
  output logic            overflow,
  output logic            zero,
  output logic            negative
);

  localparam int CW = $clog2(SIZE) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          r_state;
  logic [SIZE-1:0] r_a;
  logic [SIZE-1:0] r_b;
  logic [SIZE-1:0] r_sr;
  logic            r_c;
  logic [CW-1:0]   r_cnt;

  logic            w_sum;
  logic            w_cout;
  logic            w_last;
  logic [SIZE-1:0] w_sr_next;

  always_comb begin
    w_sum     = r_a[0] ^ r_b[0] ^ r_c;
    w_cout    = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    w_last    = (r_cnt == CW'(SIZE - 1));
    w_sr_next = {w_sum, r_sr[SIZE-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sr     <= '0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            // Subtraction as a + ~b + 1: invert b here, the +1 enters as carry-in.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_c     <= sub;
            r_sr    <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_sr  <= w_sr_next;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_cout;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            // r_c still holds the carry into the MSB on this cycle.
            result   <= w_sr_next;
            carry    <= w_cout;
            overflow <= r_c ^ w_cout;
            zero     <= (w_sr_next == '0);
            negative <= w_sum;
            done     <= 1'b1;
            busy     <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
